// File: rtl/gray_count_rx_pkg.sv
// rtl/gray_count_rx_pkg.sv - gray/binary conversion helpers shared by the gray count receiver
package gray_pkg;

   localparam int GRAY_FN_W      = 32;
   localparam int NUMBER_OF_BITS = 4;
   localparam int PTR_MAX        = (1 << NUMBER_OF_BITS) - 1;

   // Narrower counts are zero-extended into the 32-bit argument; leading zeros leave the low bits exact.
   function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] gray);
      logic [GRAY_FN_W-1:0] bin;
      bin[GRAY_FN_W-1] = gray[GRAY_FN_W-1];
      for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_count_rx_if.sv
// rtl/gray_count_rx_if.sv - event handshake between the gray count receiver and its consumer
interface gray_count_rx_if #(
   parameter int NUMBER_OF_BITS = 4
);
   logic                      ev_valid;
   logic                      ev_ready;
   logic [NUMBER_OF_BITS-1:0] pending;

   modport master (output ev_valid, output pending, input ev_ready);
   modport slave  (input ev_valid, input pending, output ev_ready);
endinterface

// File: rtl/gray_count_rx_sync.sv
// rtl/gray_count_rx_sync.sv - WIDTH-wide two-flop synchronizer with synchronous active-high reset
module sync_2ff_sr #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;

   // Nothing sits between the two stages so the first flop has a full cycle to resolve.
   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;
endmodule

// File: rtl/gray_count_rx.sv
// rtl/gray_count_rx.sv - receives a foreign-domain gray count and turns each increment into one event
module gray_count_rx
   import gray_pkg::*;
#(
   parameter int NUMBER_OF_BITS = 4,
   parameter int MAX_STEP       = 1,
   parameter int AFULL_THRESH   = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUMBER_OF_BITS-1:0] gray_in,
   gray_count_rx_if.master           ev,
   output logic [NUMBER_OF_BITS-1:0] rem_count,
   output logic                      afull,
   output logic                      step_err
);
   localparam logic [NUMBER_OF_BITS-1:0] CNT_MAX   = '1;
   localparam logic [NUMBER_OF_BITS-1:0] STEP_MAX  = NUMBER_OF_BITS'(MAX_STEP);
   localparam logic [NUMBER_OF_BITS-1:0] AFULL_LVL = NUMBER_OF_BITS'(AFULL_THRESH);

   logic [NUMBER_OF_BITS-1:0] gray_s2;
   logic [NUMBER_OF_BITS-1:0] rem_bin;
   logic [NUMBER_OF_BITS-1:0] step;
   logic [NUMBER_OF_BITS-1:0] pend;
   logic                      accept;

   logic [NUMBER_OF_BITS-1:0] rem_ptr_q, rem_ptr_d;
   logic [NUMBER_OF_BITS-1:0] loc_ptr_q, loc_ptr_d;
   logic                      step_err_q, step_err_d;

   sync_2ff_sr #(.WIDTH(NUMBER_OF_BITS)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gray_in),
      .q   (gray_s2)
   );

   always_comb begin
      rem_bin    = NUMBER_OF_BITS'(gray2bin(GRAY_FN_W'(gray_s2)));
      step       = rem_bin - rem_ptr_q;
      pend       = rem_ptr_q - loc_ptr_q;
      accept     = (pend != '0) && ev.ev_ready;
      rem_ptr_d  = rem_bin;
      loc_ptr_d  = loc_ptr_q + NUMBER_OF_BITS'(accept);
      step_err_d = step_err_q;
      // A too-large step, or one that would wrap pending past zero, is flagged but still followed.
      if ((step > STEP_MAX) || (step > (CNT_MAX - pend))) begin
         step_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_ptr_q  <= '0;
         loc_ptr_q  <= '0;
         step_err_q <= 1'b0;
      end else begin
         rem_ptr_q  <= rem_ptr_d;
         loc_ptr_q  <= loc_ptr_d;
         step_err_q <= step_err_d;
      end
   end

   assign ev.pending  = pend;
   assign ev.ev_valid = (pend != '0);
   assign rem_count   = rem_ptr_q;
   assign afull       = (pend >= AFULL_LVL);
   assign step_err    = step_err_q;
endmodule

// File: tb/tb_gray_count_rx.sv
// tb/tb_gray_count_rx.sv - randomized and directed checks of gray_count_rx against an event-count model
module tb_gray_count_rx;
   localparam int N     = 4;
   localparam int MOD   = 1 << N;
   localparam int MAXST = 1;
   localparam int AFTH  = 12;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] gray_in;
   logic [N-1:0] rem_count;
   logic         afull;
   logic         step_err;

   gray_count_rx_if #(.NUMBER_OF_BITS(N)) ev_if ();

   gray_count_rx #(.NUMBER_OF_BITS(N), .MAX_STEP(MAXST), .AFULL_THRESH(AFTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .ev        (ev_if.master),
      .rem_count (rem_count),
      .afull     (afull),
      .step_err  (step_err)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Model: source value seen two samples late, remote and consumed totals, sticky error.
   int dec_tab [MOD];
   int hist1, hist2;
   int m_rem, m_loc;
   bit m_err;
   int src_bin;

   task automatic check_val(input string tag, input int obs, input int exp);
      vec_cnt++;
      if (obs != exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int to_gray(input int b);
      return (b ^ (b >> 1)) % MOD;
   endfunction

   function automatic int m_pending();
      return ((m_rem - m_loc) % MOD + MOD) % MOD;
   endfunction

   task automatic model_edge(input int g, input bit rdy, input bit r);
      int pend, nb, st;
      if (r) begin
         hist1 = 0; hist2 = 0; m_rem = 0; m_loc = 0; m_err = 1'b0;
      end else begin
         pend = m_pending();
         nb   = dec_tab[hist2];
         st   = ((nb - m_rem) % MOD + MOD) % MOD;
         if (st > MAXST || st > (MOD - 1 - pend)) m_err = 1'b1;
         if (pend != 0 && rdy) m_loc = (m_loc + 1) % MOD;
         m_rem = nb;
         hist2 = hist1;
         hist1 = g;
      end
   endtask

   task automatic check_outputs();
      check_val("pending",   int'(ev_if.pending), m_pending());
      check_val("ev_valid",  int'(ev_if.ev_valid), int'(m_pending() != 0));
      check_val("rem_count", int'(rem_count), m_rem);
      check_val("afull",     int'(afull), int'(m_pending() >= AFTH));
      check_val("step_err",  int'(step_err), int'(m_err));
   endtask

   // Called just after a falling edge: apply inputs, advance model, take the edge, check at the next fall.
   task automatic cycle(input int g, input bit rdy, input bit r);
      gray_in         = N'(g);
      ev_if.ev_ready  = rdy;
      rst             = r;
      model_edge(g, rdy, r);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic hold(input int g, input bit rdy, input int n);
      for (int i = 0; i < n; i++) cycle(g, rdy, 1'b0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) cycle(0, 1'b0, 1'b1);
      src_bin = 0;
   endtask

   initial begin
      for (int i = 0; i < MOD; i++) dec_tab[to_gray(i)] = i;
      hist1 = 0; hist2 = 0; m_rem = 0; m_loc = 0; m_err = 1'b0;
      gray_in = '0; ev_if.ev_ready = 1'b0; rst = 1'b1;
      @(negedge clk);

      do_reset();
      check_val("rst_pending", int'(ev_if.pending), 0);
      check_val("rst_step_err", int'(step_err), 0);
      hold(0, 1'b0, 10);
      check_val("idle_valid", int'(ev_if.ev_valid), 0);

      hold(to_gray(1), 1'b0, 4);
      hold(to_gray(2), 1'b0, 4);
      check_val("two_pending", int'(ev_if.pending), 2);
      check_val("two_rem", int'(rem_count), 2);
      hold(to_gray(2), 1'b1, 3);
      check_val("drained_pending", int'(ev_if.pending), 0);
      check_val("drained_valid", int'(ev_if.ev_valid), 0);

      src_bin = 2;
      for (int i = 0; i < 32; i++) begin
         src_bin = (src_bin + 1) % MOD;
         hold(to_gray(src_bin), 1'b1, 2);
      end
      hold(to_gray(src_bin), 1'b1, 4);
      check_val("wrap_pending", int'(ev_if.pending), 0);
      check_val("wrap_rem", int'(rem_count), 2);
      check_val("wrap_step_err", int'(step_err), 0);

      do_reset();
      for (int b = 1; b <= 12; b++) hold(to_gray(b), 1'b0, 1);
      hold(to_gray(12), 1'b0, 3);
      check_val("afull_at_12", int'(afull), 1);
      check_val("afull_pending", int'(ev_if.pending), 12);
      hold(to_gray(12), 1'b1, 1);
      check_val("afull_below", int'(afull), 0);

      do_reset();
      hold(to_gray(1), 1'b1, 4);
      hold(to_gray(3), 1'b1, 4);
      check_val("jump_step_err", int'(step_err), 1);
      hold(to_gray(3), 1'b1, 6);
      check_val("jump_sticky", int'(step_err), 1);

      do_reset();
      for (int b = 1; b <= 5; b++) hold(to_gray(b), 1'b0, 1);
      hold(to_gray(5), 1'b0, 3);
      check_val("pre_rst_pending", int'(ev_if.pending), 5);
      cycle(0, 1'b0, 1'b1);
      check_val("mid_rst_pending", int'(ev_if.pending), 0);
      check_val("mid_rst_rem", int'(rem_count), 0);
      hold(0, 1'b1, 8);
      check_val("post_rst_err", int'(step_err), 0);

      for (int pass = 0; pass < 3; pass++) begin
         do_reset();
         for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               src_bin = (src_bin + (($urandom_range(0, 29) == 0) ? 2 : 1)) % MOD;
            end
            cycle(to_gray(src_bin), 1'(($urandom_range(0, 3) != 0) ^ (pass == 2)), 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
